dm_bus_bridge: RTL and testbench

Data-memory bus bridge sitting directly downstream of the multicycle CPU's memory-access path. It replaces the CPU's zero-wait-state data-memory connection with a valid/ready request bus so that wait-stated or slow memories can be attached. A stall output holds the control unit in its memory state until the access completes. Each access is latched at acceptance, checked for word alignment, issued, and finished with a single-cycle done pulse; read data is held in a register.

---
 rtl/dm_bus_bridge_pkg.sv | 14 +
 rtl/dm_bus_bridge_if.sv | 22 ++
 rtl/dm_bus_bridge.sv | 99 +++++++++
 tb/tb_dm_bus_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_bus_bridge_pkg.sv
// dm_bus_pkg: shared state encoding and alignment mask for the data-memory bus bridge.
package dm_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } dm_bus_state_t;

    // Byte-offset bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dm_bus_bridge_if.sv
// dm_bus_if: valid/ready data-memory request bus; master = bridge, slave = memory.
interface dm_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dm_bus_bridge.sv
// dm_bus_bridge: stalls the CPU memory state while a latched, word-aligned access runs on dm_bus_if; optional REQ timeout via DM_BUS_TIMEOUT_EN.
module dm_bus_bridge
    import dm_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic              cpu_err,
    dm_bus_if.master          bus
);

    dm_bus_state_t     state, state_nx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              aligned;
    logic              expired;

    assign aligned = (cpu_addr[1:0] & ALIGN_MASK) == 2'b00;

`ifdef DM_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt;

    // Expires on the last permitted wait cycle so mem_valid is high exactly TIMEOUT_CYC cycles.
    assign expired = cnt == CNT_W'(TIMEOUT_CYC - 1);

    // Wait-cycle counter: held at zero outside REQ, so it is clear on every REQ entry.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (state != REQ)
            cnt <= '0;
        else if (!bus.mem_ready)
            cnt <= cnt + 1'b1;
    end
`else
    // Without the timeout feature REQ never expires.
    assign expired = TIMEOUT_CYC < 0;
`endif

    // State register; reset drops mem_valid immediately because it decodes REQ.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state: mem_ready beats an expiring timeout in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cpu_req ? (aligned ? REQ : ERR) : IDLE;
            REQ:     state_nx = bus.mem_ready ? DONE : (expired ? ERR : REQ);
            default: state_nx = IDLE;
        endcase
    end

    // Access latch on acceptance and read-data capture on a read handshake.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && cpu_req && aligned) begin
                we_q    <= cpu_we;
                addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                wdata_q <= cpu_wdata;
            end
            if (state == REQ && bus.mem_ready && !we_q)
                rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_valid = state == REQ;
    assign bus.mem_we    = state == REQ && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_rdata     = rdata_q;
    assign cpu_done      = state == DONE || state == ERR;
    assign cpu_err       = state == ERR;
    assign cpu_stall     = reset && ((state == IDLE && cpu_req) || state == REQ);

endmodule

// File: tb/tb_dm_bus_bridge.sv
// tb_dm_bus_bridge: scoreboard bench for dm_bus_bridge; follows DM_BUS_TIMEOUT_EN for the timeout scenario.
module tb_dm_bus_bridge;

`ifdef DM_BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        cpu_err;

    always #5 clk = ~clk;

    dm_bus_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dm_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .CLK       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .bus       (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } done_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    done_t       done_q[$];
    xfer_t       bus_q[$];
    done_t       d;
    xfer_t       x;
    logic [31:0] model_rdata = '0;

    // Expected completion and bus transfer for one CPU access.
    task automatic expect_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic err);
        if (!err) bus_q.push_back('{we, {addr[31:2], 2'b00}, wdata});
        if (!err && !we) model_rdata = rdata;
        done_q.push_back('{err, model_rdata});
    endtask

    // Scoreboard: pop on every bus handshake and every done pulse.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            if (bus.mem_valid && bus.mem_ready) begin
                if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
                else begin
                    x = bus_q.pop_front();
                    check("bus_we", bus.mem_we, x.we);
                    check("bus_addr", bus.mem_addr, x.addr);
                    if (x.we) check("bus_wdata", bus.mem_wdata, x.wdata);
                end
            end
            if (cpu_done) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    d = done_q.pop_front();
                    check("done_err", cpu_err, d.err);
                    check("done_rdata", cpu_rdata, d.rdata);
                end
            end else if (cpu_err) check("err_without_done", 1, 0);
        end
    end

    // One access against a slave inserting `waits` wait states; scrambles CPU inputs after acceptance.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits, input string tag);
        bit mis = addr[1:0] != 2'b00;
        int cyc = 0;
        int nvalid = 0;
        bit got = 0;
        expect_access(we, addr, wdata, rdata, mis);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        bus.mem_ready = 1'b0;
        #1 check({tag, "_stall_c0"}, cpu_stall, 1);
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                cpu_we = ~we; cpu_addr = addr ^ 32'h0000_FFF0; cpu_wdata = ~wdata;
            end
            if (bus.mem_valid) begin
                nvalid++;
                check({tag, "_hold_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
                check({tag, "_hold_we"}, bus.mem_we, we);
                if (we) check({tag, "_hold_wdata"}, bus.mem_wdata, wdata);
                bus.mem_ready = nvalid == waits + 1;
                bus.mem_rdata = bus.mem_ready ? rdata : 32'hBAD0_BAD0;
            end else
                bus.mem_ready = 1'b0;
            if (cpu_done) begin
                got = 1;
                check({tag, "_done_cycle"}, cyc, mis ? 1 : waits + 2);
                check({tag, "_valid_cycles"}, nvalid, mis ? 0 : waits + 1);
                check({tag, "_stall_done"}, cpu_stall, 0);
                cpu_req = 1'b0;
            end
        end
        if (!got) check({tag, "_done_timeout"}, 0, 1);
        cpu_req = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int nvalid;
        int stalls;
        bit got;
        logic [5:0] pat;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        cpu_req = 1'b1;
        #12;
        check("rst_stall", cpu_stall, 0);
        check("rst_valid", bus.mem_valid, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_done", cpu_done, 0);
        check("rst_err", cpu_err, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_rdata", cpu_rdata, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        access(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, "rd0");
        access(1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 3, "wr3");
        access(1'b0, 32'h0000_0013, 32'h0, 32'h0, 0, "unal_rd");
        access(1'b1, 32'h0000_0FFE, 32'h5555_AAAA, 32'h0, 0, "unal_wr");
        access(1'b0, 32'h8000_0004, 32'h0, 32'h5A5A_A5A5, 1, "rd1");

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; bus.mem_ready = 1'b0;
`ifdef DM_BUS_TIMEOUT_EN
        expect_access(1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        cyc = 0; nvalid = 0; got = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_valid) nvalid++;
            if (cpu_done) begin
                got = 1;
                check("to_err", cpu_err, 1);
                check("to_cycle", cyc, TO + 1);
                check("to_valid_cycles", nvalid, TO);
                cpu_req = 1'b0;
            end
        end
        if (!got) check("to_done_timeout", 0, 1);
        cpu_req = 1'b0;
        @(negedge clk);
`else
        expect_access(1'b0, 32'h40, 32'h0, 32'h7777_0001, 1'b0);
        stalls = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cpu_stall && bus.mem_valid && !cpu_done) stalls++;
        end
        check("nto_stall_cycles", stalls, 1000);
        bus.mem_rdata = 32'h7777_0001;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("nto_done", cpu_done, 1);
        cpu_req = 1'b0;
        @(negedge clk);
`endif

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; bus.mem_ready = 1'b0;
        @(negedge clk);
        check("rstreq_valid_pre", bus.mem_valid, 1);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("rstreq_valid", bus.mem_valid, 0);
        check("rstreq_stall", cpu_stall, 0);
        check("rstreq_rdata", cpu_rdata, 0);
        model_rdata = '0;
        @(negedge clk);
        check("rstreq_done", cpu_done, 0);
        cpu_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rstreq_done_after", cpu_done, 0);
        access(1'b0, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1, "post_rst");

        expect_access(1'b0, 32'h30, 32'h0, 32'h1111_2222, 1'b0);
        expect_access(1'b0, 32'h30, 32'h0, 32'h3333_4444, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_2222;
        pat = '0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 3) bus.mem_rdata = 32'h3333_4444;
            pat[c] = bus.mem_valid;
            if (c == 5) cpu_req = 1'b0;
        end
        check("b2b_valid_pattern", pat, 6'b010010);
        bus.mem_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 32'h3FFF), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            access(1'($urandom_range(0, 1)), a, $urandom, $urandom, int'($urandom_range(0, 3)), "rand");
        end

        check("sb_done_empty", done_q.size(), 0);
        check("sb_bus_empty", bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
